rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-way arbiter that shares one resource among eight requesters. Selection uses the same priority order as the team's 8-input priority encoder: bit 7 is highest, and the granted index is reported as a 3-bit code. Grants are held until the requester releases or a hold timer preempts it. An optional round-robin pointer rotates priority. The block sits between requester front-ends and the shared datapath, and drives its select/enable.

## Interface
- MAX_HOLD, default 16: maximum consecutive grant cycles before preemption when other requests are pending. Legal range 2..255.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; req[i] high means requester i wants the resource.
- grant  output  8  one-hot grant, registered; all zero when nothing is granted.
- grant_valid  output  1  high when grant is nonzero, registered.
- grant_code  output  3  binary index of the granted requester, registered; 000 when grant_valid is low.

## Operation
- FSM has two states: IDLE and GRANT.
- **IDLE:**
  - If req is nonzero, select the winner, load grant, grant_code and grant_valid, clear the hold counter, and go to GRANT.
  - Otherwise stay in IDLE with all outputs zero.
- **GRANT (granted index g):**
  - Release: if req[g] is low, clear outputs and go to IDLE. Other requests are not considered on this edge, so there is a one-cycle bubble.
  - Preemption: else if the hold counter equals MAX_HOLD-1 and req has any bit other than g set, clear outputs and go to IDLE.
  - Else stay in GRANT and increment the hold counter, saturating at MAX_HOLD-1. A lone requester is never preempted.
- Counter width is $clog2(MAX_HOLD) bits. The counter is reset on every new grant.
- **Winner selection** is combinational from req and the pointer; only registered results are visible at the outputs.
- **Fixed order:** 7, 6, 5, …, 0.
- **Rotated order (Configuration):** with pointer p equal to the last granted index, the order is p-1, p-2, …, 0, 7, …, p. Index p has lowest priority. Wrap-around is modulo 8.
- grant, grant_code and grant_valid always agree: grant == (1 << grant_code) when valid.
- req changes while in GRANT never alter grant mid-hold, except through release or preemption.

## Timing
- **Reset:** on a rising edge with rst high, the state goes to IDLE, grant = 8'h00, grant_valid = 0, grant_code = 3'b000, hold counter = 0 and pointer = 0. The pointer value 0 makes the rotated order start at 7..0.
- rst takes priority over every other event, including mid-grant; outputs are zero in the cycle after that edge.
- **Grant latency:** req sampled at edge N produces grant from edge N onward, visible in cycle N+1.
- **Release latency:** req[g] low at edge N gives grant zero in cycle N+1. The next grant is visible in cycle N+2 at the earliest.
- **Hold length:** a preempted grant is visible for exactly MAX_HOLD cycles, followed by one zero cycle.
- **Simultaneous events:**
  - Release and timeout on the same edge is treated as a release.
  - A release with other requests pending still gives the one-cycle bubble.

## Configuration
- RR_ARBITER8_ROUND_ROBIN_EN
  - **Defined:** the pointer register is compiled in. It updates to g on every transition into GRANT, and the rotated order applies.
  - **Undefined:** there is no pointer and the fixed 7..0 order always applies. After preemption, the highest pending index is re-granted, which may be the same requester. The timer then only enforces the bubble.

## Test plan
- **Reset:** hold rst=1 for 2 cycles with req=8'hFF.
  - Required: grant=00, grant_valid=0, grant_code=000 during reset and in the cycle after rst falls.
  - Required: grant=80, grant_code=111 in the following cycle.
- **Priority and hold:** from IDLE apply req=8'b0100_0100.
  - Required: next cycle grant=8'b0100_0000, grant_code=110, grant_valid=1.
  - Required: the grant is held while req[6] stays high (held fewer than MAX_HOLD cycles).
- **Release:** with bit 6 granted, drop req[6] and keep req[2].
  - Required: grant=00 for one cycle, then grant=8'b0000_0100, grant_code=010.
- **Preemption with MAX_HOLD=4 and req=8'hFF held:**
  - ROUND_ROBIN_EN defined: codes 7,6,5,4,3,2,1,0,7, each visible for 4 cycles and separated by one zero cycle.
  - ROUND_ROBIN_EN undefined: code 7 repeated with the same 4-on/1-off pattern.
- **Lone requester:** with MAX_HOLD=4, apply req=8'b0000_0001 for 20 cycles.
  - Required: grant_code=000 with grant_valid=1 continuously, and no bubble.
- **Mid-grant reset:** assert rst in the 2nd cycle of a grant to bit 5.
  - Required: outputs are zero in the next cycle.
  - Required: with req=8'b0010_0001 kept and ROUND_ROBIN_EN defined, the post-reset grant is bit 5, confirming the pointer was cleared.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way arbiter for one shared resource.
// Highest request index wins (7..0) and a grant is held until its requester
// releases it, or until a hold timer preempts it while others are waiting.
// Every grant/release passes through IDLE, so there is always one bubble cycle
// between two grants.
// Optional feature macro: RR_ARBITER8_ROUND_ROBIN_EN
//   defined   - a pointer remembers the last granted index; the search starts
//               just below it and wraps, so that index gets lowest priority.
//   undefined - fixed 7..0 order; after preemption the same requester may win
//               again, and the timer then only enforces the bubble.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic [2:0] grant_code
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       win_code_c;

`ifdef RR_ARBITER8_ROUND_ROBIN_EN
  logic [2:0] ptr_q;
  logic [2:0] idx_c;

  // Winner search from ptr_q-1 downward with wrap; ptr_q itself is checked last.
  always_comb begin
    win_code_c = 3'd0;
    idx_c      = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      idx_c = ptr_q - 3'(k);
      if (req[idx_c]) begin
        win_code_c = idx_c;
      end
    end
  end
`else
  // Winner search in fixed order: the highest requesting index wins.
  always_comb begin
    win_code_c = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) begin
        win_code_c = 3'(i);
      end
    end
  end
`endif

  // Grant FSM: state, hold counter, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant       <= 8'h00;
      grant_valid <= 1'b0;
      grant_code  <= 3'b000;
      cnt_q       <= '0;
`ifdef RR_ARBITER8_ROUND_ROBIN_EN
      ptr_q       <= 3'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q     <= GRANT;
            grant       <= 8'b0000_0001 << win_code_c;
            grant_valid <= 1'b1;
            grant_code  <= win_code_c;
            cnt_q       <= '0;
`ifdef RR_ARBITER8_ROUND_ROBIN_EN
            ptr_q       <= win_code_c;
`endif
          end
        end
        GRANT: begin
          if (!req[grant_code]) begin
            // Release wins over timeout on the same edge.
            state_q     <= IDLE;
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            grant_code  <= 3'b000;
          end else if ((cnt_q == HOLD_LAST) && (|(req & ~grant))) begin
            state_q     <= IDLE;
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            grant_code  <= 3'b000;
          end else if (cnt_q != HOLD_LAST) begin
            // Saturates so a lone requester keeps the grant indefinitely.
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          grant       <= 8'h00;
          grant_valid <= 1'b0;
          grant_code  <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8 (MAX_HOLD=4): directed literal checks of the documented
// scenarios, then randomized traffic compared every cycle against a
// behavioural model (grant owner, cycles visible so far, last-granted pointer).
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_code;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_code  (grant_code)
  );

  always #5 clk = ~clk;

  // Model state: owner index (-1 when idle), visible cycles so far, pointer.
  int m_g    = -1;
  int m_held = 0;
  int m_ptr  = 0;
  bit live   = 1'b0;

  // First requesting index in the order ptr-1, ptr-2, ... (mod 8), ptr last.
  function automatic int pick(logic [7:0] r, int p);
    int idx;
    for (int k = 1; k <= 8; k++) begin
      idx = (p - k + 16) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_g = -1; m_held = 0; m_ptr = 0; live = 1'b1;
    end else if (live) begin
      if (m_g < 0) begin
        if (req != 8'h00) begin
          m_g = pick(req, m_ptr);
          m_held = 1;
`ifdef RR_ARBITER8_ROUND_ROBIN_EN
          m_ptr = m_g;
`endif
        end
      end else if (!req[m_g]) begin
        m_g = -1;
      end else if (m_held >= MH && (req & ~(8'(1) << m_g)) != 8'h00) begin
        m_g = -1;
      end else begin
        m_held = m_held + 1;
      end
    end
  end

  // Continuous comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [7:0] eg;
    logic [2:0] ec;
    logic       ev;
    if (live) begin
      eg = (m_g < 0) ? 8'h00 : (8'(1) << m_g);
      ec = (m_g < 0) ? 3'd0 : 3'(m_g);
      ev = (m_g >= 0);
      n_cmp++;
      if (grant !== eg || grant_code !== ec || grant_valid !== ev) begin
        n_bad++;
        $display("FAIL model t=%0t req=%h: got grant=%h code=%0d valid=%b, want grant=%h code=%0d valid=%b",
                 $time, req, grant, grant_code, grant_valid, eg, ec, ev);
      end
    end
  end

  task automatic drive(input logic [7:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
  endtask

  task automatic lit(input string name, input logic [7:0] g, input logic [2:0] c, input logic v);
    n_cmp++;
    if (grant !== g || grant_code !== c || grant_valid !== v) begin
      n_bad++;
      $display("FAIL %s: got grant=%h code=%0d valid=%b, want grant=%h code=%0d valid=%b",
               name, grant, grant_code, grant_valid, g, c, v);
    end
  endtask

  initial begin
    logic [7:0] flip;
    logic [7:0] eg;
    logic [2:0] ec;
    req = 8'hFF;
    rst = 1'b1;

    // Reset with all requests active.
    drive(8'hFF, 1'b1);
    drive(8'hFF, 1'b1);  lit("reset_1", 8'h00, 3'd0, 1'b0);
    drive(8'hFF, 1'b0);  lit("reset_2", 8'h00, 3'd0, 1'b0);
    drive(8'hFF, 1'b0);  lit("first_grant", 8'h80, 3'd7, 1'b1);

    // Priority, hold, release with one bubble.
    drive(8'h44, 1'b1);
    drive(8'h44, 1'b0);  lit("prio_reset", 8'h00, 3'd0, 1'b0);
    drive(8'h44, 1'b0);  lit("prio_grant", 8'h40, 3'd6, 1'b1);
    drive(8'h44, 1'b0);  lit("hold_2", 8'h40, 3'd6, 1'b1);
    drive(8'h04, 1'b0);  lit("hold_3", 8'h40, 3'd6, 1'b1);
    drive(8'h04, 1'b0);  lit("release_bubble", 8'h00, 3'd0, 1'b0);
    drive(8'h04, 1'b0);  lit("release_next", 8'h04, 3'd2, 1'b1);

    // Preemption with everyone requesting: 4 cycles on, 1 off.
    drive(8'hFF, 1'b1);
    drive(8'hFF, 1'b0);
    for (int i = 0; i < 45; i++) begin
      drive(8'hFF, 1'b0);
      if (i % 5 == 4) begin
        lit("preempt_gap", 8'h00, 3'd0, 1'b0);
      end else begin
`ifdef RR_ARBITER8_ROUND_ROBIN_EN
        ec = 3'(7 - ((i / 5) % 8));
`else
        ec = 3'd7;
`endif
        eg = 8'(1) << ec;
        lit("preempt_on", eg, ec, 1'b1);
      end
    end

    // Lone requester never preempted.
    drive(8'h01, 1'b1);
    drive(8'h01, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(8'h01, 1'b0);
      lit("lone", 8'h01, 3'd0, 1'b1);
    end

    // Reset in the second cycle of a grant to bit 5.
    drive(8'h21, 1'b1);
    drive(8'h21, 1'b0);
    drive(8'h21, 1'b0);  lit("mid_first", 8'h20, 3'd5, 1'b1);
    drive(8'h21, 1'b1);  lit("mid_second", 8'h20, 3'd5, 1'b1);
    drive(8'h21, 1'b0);  lit("mid_reset", 8'h00, 3'd0, 1'b0);
    drive(8'h21, 1'b0);  lit("post_reset", 8'h20, 3'd5, 1'b1);

    // Randomized traffic: sticky requests with random flips and rare resets.
    for (int i = 0; i < 4000; i++) begin
      flip = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 9) == 0) flip[b] = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) begin
        drive(8'($urandom), 1'b0);
      end else begin
        drive(req ^ flip, ($urandom_range(0, 299) == 0));
      end
    end
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
